// File: rtl/athos_ip_pkg.sv
`default_nettype none
// ============================================================================
// athos_ip_pkg : shared operation codes and host-bridge types for athos_ip
// Revision 1.0 : initial release
// ============================================================================
package athos_ip_pkg;

  localparam logic [6:0] NULL   = 7'h00;
  localparam logic [6:0] KECCAK = 7'h01;
  localparam logic [6:0] NTT    = 7'h02;

  localparam int WORDS_PER_STATE = 50;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    UNLOAD = 2'd3
  } bridge_state_e;

endpackage
`default_nettype wire

// File: rtl/athos_ip_word_buf.sv
`default_nettype none
// ============================================================================
// athos_ip_word_buf : word-addressable state buffer with full-width load/view
// Revision 1.0 : initial release
// ============================================================================
module athos_ip_word_buf #(
  parameter int WORD_W = 32,
  parameter int DATA_W = 1600,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              ld_en,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_word
);

  logic [DATA_W-1:0] r_data;

  // Full-width load wins: it only happens in RUN, word writes only in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (ld_en) begin
      r_data <= ld_data;
    end else if (wr_en) begin
      r_data[int'(wr_idx)*WORD_W +: WORD_W] <= wr_word;
    end
  end

  assign data    = r_data;
  assign rd_word = r_data[int'(rd_idx)*WORD_W +: WORD_W];

endmodule
`default_nettype wire

// File: rtl/athos_ip_host_bridge.sv
`default_nettype none
// ============================================================================
// athos_ip_host_bridge : packs bus words into athos_ip, launches, unloads result
// Revision 1.0 : initial release
// ============================================================================
module athos_ip_host_bridge
  import athos_ip_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int DATA_W         = 1600,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              start_i,
  input  logic [6:0]        op_i,
  input  logic [9:0]        ctrl_i,
  output logic [DATA_W-1:0] ip_data_o,
  output logic [16:0]       ip_ctrl_o,
  input  logic              ip_done_i,
  input  logic [DATA_W-1:0] ip_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              intr_o,
  output logic              err_o
);

  localparam int               N_WORDS    = DATA_W / WORD_W;
  localparam int               CNT_W      = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(N_WORDS - 1);
  localparam logic [31:0]      C_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  bridge_state_e     r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_rd_idx;
  logic [31:0]       r_timer;
  logic [16:0]       r_ip_ctrl;
  logic              r_err, r_intr;
  logic [WORD_W-1:0] r_rd_data, w_rd_word;
  logic              w_wr_hs, w_rd_hs, w_start_ok, w_bad_start, w_done, w_tmo;

  assign w_wr_hs     = (r_state == LOAD) && wr_valid_i;
  assign w_rd_hs     = (r_state == UNLOAD) && rd_ready_i;
  assign w_start_ok  = (r_state == ARMED) && start_i && (op_i != NULL);
  assign w_bad_start = start_i && ((r_state == LOAD) || ((r_state == ARMED) && (op_i == NULL)));
  assign w_done      = (r_state == RUN) && ip_done_i;
  assign w_tmo       = (r_state == RUN) && !ip_done_i && (TIMEOUT_CYCLES != 0) &&
                       (r_timer == C_TMO_LAST);

  // Read port looks one word ahead so rd_data_o can be registered.
  assign w_rd_idx = ((r_state == UNLOAD) && (r_cnt != C_LAST)) ? r_cnt + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD:    if (w_wr_hs && (r_cnt == C_LAST)) w_state_next = ARMED;
      ARMED:   if (w_start_ok)                   w_state_next = RUN;
      RUN:     if (w_done || w_tmo)              w_state_next = UNLOAD;
      UNLOAD:  if (w_rd_hs && (r_cnt == C_LAST)) w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timer   <= '0;
      r_ip_ctrl <= '0;
      r_err     <= 1'b0;
      r_intr    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_hs || w_rd_hs) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;

      if (w_start_ok)            r_timer <= '0;
      else if (r_state == RUN)   r_timer <= r_timer + 32'd1;

      if (w_start_ok)            r_ip_ctrl <= {ctrl_i, op_i};
      else if (w_done || w_tmo)  r_ip_ctrl <= '0;

      if (w_bad_start || w_tmo)  r_err <= 1'b1;
      r_intr <= w_done || w_tmo;

      // On completion word 0 comes straight from the IP, buffer is loading in parallel.
      if (w_done)                r_rd_data <= ip_data_i[WORD_W-1:0];
      else if (w_tmo || w_rd_hs) r_rd_data <= w_rd_word;
    end
  end

  athos_ip_word_buf #(
    .WORD_W (WORD_W),
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_word_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_hs),
    .wr_idx  (r_cnt),
    .wr_word (wr_data_i),
    .ld_en   (w_done),
    .ld_data (ip_data_i),
    .data    (ip_data_o),
    .rd_idx  (w_rd_idx),
    .rd_word (w_rd_word)
  );

  assign wr_ready_o = (r_state == LOAD);
  assign rd_valid_o = (r_state == UNLOAD);
  assign busy_o     = (r_state == ARMED) || (r_state == RUN);
  assign ip_ctrl_o  = r_ip_ctrl;
  assign intr_o     = r_intr;
  assign err_o      = r_err;
  assign rd_data_o  = r_rd_data;

endmodule
`default_nettype wire
